bsg_mesh_out_port_sched: RTL and testbench
==========================================

Name: bsg_mesh_out_port_sched

Overview:
- Per-output-port scheduler for the mesh router crossbar; one instance per output direction (P, W, E, N, S).
- Shares one output link among up to dirs_p input directions using round-robin arbitration.
- Returns yumi to the winning input and drives the output link through a single registered stage with valid/ready_and backpressure.
- Flags illegal (routing-forbidden) requests and inputs stalled beyond a watchdog limit, so the mesh formal and sim checkers can observe progress.

Parameters:
- dirs_p, 5, number of requesting input directions (P=0, W=1, E=2, N=3, S=4).
- width_p, 10, flit width (data plus x/y coordinate fields), passed through unmodified.
- allowed_mask_p, 5'b11111, bit k=1 means input k may route to this output under XY routing.
- max_wait_p, 15, saturation value of the per-input wait counter (must be >=1).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- v_i  in  dirs_p  per-input valid.
- data_i  in  dirs_p x width_p  per-input flit.
- yumi_o  out  dirs_p  one-hot-or-zero dequeue to the input FIFO; same cycle as the grant.
- v_o  out  1  output link valid.
- data_o  out  width_p  output link flit.
- ready_and_i  in  1  downstream ready.
- grant_idx_o  out  $clog2(dirs_p)  index of the last granted input.
- starve_o  out  dirs_p  input k has waited max_wait_p cycles.
- illegal_o  out  1  sticky: a forbidden input requested.

Behaviour:
- Reset (async, takes effect immediately):
  - v_o=0, data_o=0, yumi_o=0.
  - last-grant pointer = dirs_p-1, so input 0 has top priority after reset; grant_idx_o = dirs_p-1.
  - All wait counters = 0, starve_o=0, illegal_o=0.
  - yumi_o is forced to 0 while reset is high.
- Eligibility: elig = v_i & allowed_mask_p.
- Output space: space = !v_o | ready_and_i.
- Load condition: load = (|elig) & space & !reset.
- Priority: search order starts at (last_grant+1) mod dirs_p and wraps; the first set bit of elig wins. Modulo wrap at dirs_p-1 -> 0 is required; no power-of-two assumption.
- On load (combinational, same cycle): yumi_o[winner]=1. All other yumi_o bits are 0.
- On load (next edge): data_o<=data_i[winner], v_o<=1, last_grant<=winner.
- No load and v_o & ready_and_i: v_o<=0 at the edge; data_o keeps its value.
- Simultaneous drain and load (v_o & ready_and_i & load): v_o stays 1 and data_o takes the new flit. This gives full throughput of 1 flit/cycle.
- Backpressure (v_o & !ready_and_i): data_o and v_o are held stable, yumi_o=0, last_grant is unchanged.
- Latency: input flit appears on data_o one cycle after its yumi.
- yumi_o is never asserted without the corresponding v_i, and never for a masked input.
- Wait counter k (width $clog2(max_wait_p+1)):
  - Clears when !elig[k] or yumi_o[k].
  - Otherwise increments, saturating at max_wait_p.
  - starve_o[k] = (count_k == max_wait_p), registered.
- Starvation bound: with ready_and_i held high, no eligible input waits more than dirs_p-1 grants. starve_o asserting under continuous ready_and_i is a design bug.
- Illegal requests: illegal_o is set at the edge after any cycle with v_i & ~allowed_mask_p != 0. It stays set until reset. Masked requests are otherwise ignored.
- Reset mid-transfer: the pending flit in the output register is dropped (v_o=0) and is not re-requested. The upstream input FIFO has not been yumi'd in the reset cycle, so nothing is lost upstream.
- data_o is not X-masked when v_o=0; checkers compare data only when v_o=1.

Test Plan:
- Reset: assert reset mid-cycle with v_o=1 -> v_o=0, data_o=0, grant_idx_o=4, yumi_o=0 immediately, before the next edge.
- Single requester: v_i=5'b00001, data_i[0]=10'h2A5, ready_and_i=1 -> yumi_o=5'b00001 at cycle 0; v_o=1, data_o=10'h2A5 at cycle 1.
- Fairness: all five inputs valid for 10 cycles, ready_and_i=1 -> grant sequence 0,1,2,3,4,0,1,2,3,4, one yumi per cycle, v_o continuous.
- Backpressure: v_o=1, ready_and_i=0 for 3 cycles with v_i=5'b00110 -> data_o stable, yumi_o=0; wait counters for inputs 1 and 2 reach 3. ready_and_i=1 -> input 1 yumi'd the same cycle.
- Starvation flag: max_wait_p=4, ready_and_i=0 for 6 cycles with v_i[3]=1 -> starve_o[3]=1 from cycle 4. It clears the cycle after yumi_o[3].
- Illegal request: allowed_mask_p=5'b11101, v_i=5'b00010 -> yumi_o stays 0, v_o stays 0, illegal_o=1 next cycle and sticky until reset.

Source files
------------

// File: rtl/bsg_mesh_out_port_sched.sv
// rtl/bsg_mesh_out_port_sched.sv - round-robin output-port scheduler with one registered output stage
module bsg_mesh_out_port_sched #(
  parameter int                dirs_p         = 5,
  parameter int                width_p        = 10,
  parameter logic [dirs_p-1:0] allowed_mask_p = 5'b11111,
  parameter int                max_wait_p     = 15
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [dirs_p-1:0]           v_i,
  input  logic [dirs_p*width_p-1:0]   data_i,
  output logic [dirs_p-1:0]           yumi_o,
  output logic                        v_o,
  output logic [width_p-1:0]          data_o,
  input  logic                        ready_and_i,
  output logic [$clog2(dirs_p)-1:0]   grant_idx_o,
  output logic [dirs_p-1:0]           starve_o,
  output logic                        illegal_o
);

  localparam int idx_w = $clog2(dirs_p);
  localparam int cnt_w = $clog2(max_wait_p + 1);
  localparam logic [cnt_w-1:0] cnt_max  = cnt_w'(max_wait_p);
  localparam logic [idx_w-1:0] last_rst = idx_w'(dirs_p - 1);

  logic                          v_q, v_d;
  logic [width_p-1:0]            data_q, data_d;
  logic [idx_w-1:0]              last_q, last_d;
  logic [dirs_p-1:0][cnt_w-1:0]  cnt_q, cnt_d;
  logic                          illegal_q, illegal_d;

  logic [dirs_p-1:0]   elig;
  logic [dirs_p-1:0]   yumi;
  logic                space;
  logic                load;
  logic [idx_w-1:0]    winner;
  logic [width_p-1:0]  win_data;
  int                  cand;

  assign elig  = v_i & allowed_mask_p;
  assign space = ~v_q | ready_and_i;
  assign load  = (|elig) & space & ~reset;

  // Walk the search order backwards so the first eligible input after last_q is the final assignment.
  always_comb begin
    winner   = last_q;
    win_data = '0;
    cand     = 0;
    for (int i = dirs_p; i >= 1; i--) begin
      cand = (int'(last_q) + i) % dirs_p;
      if (elig[cand]) begin
        winner   = idx_w'(cand);
        win_data = data_i[cand*width_p +: width_p];
      end
    end
  end

  always_comb begin
    yumi = '0;
    if (load) yumi[winner] = 1'b1;
  end

  always_comb begin
    v_d       = v_q;
    data_d    = data_q;
    last_d    = last_q;
    illegal_d = illegal_q | (|(v_i & ~allowed_mask_p));
    if (load) begin
      v_d    = 1'b1;
      data_d = win_data;
      last_d = winner;
    end else if (v_q & ready_and_i) begin
      v_d = 1'b0;
    end
    for (int k = 0; k < dirs_p; k++) begin
      if (!elig[k] || yumi[k]) cnt_d[k] = '0;
      else if (cnt_q[k] != cnt_max) cnt_d[k] = cnt_q[k] + cnt_w'(1);
      else cnt_d[k] = cnt_q[k];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q       <= 1'b0;
      data_q    <= '0;
      last_q    <= last_rst;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      v_q       <= v_d;
      data_q    <= data_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    starve_o = '0;
    for (int k = 0; k < dirs_p; k++) starve_o[k] = (cnt_q[k] == cnt_max);
  end

  assign yumi_o      = yumi;
  assign v_o         = v_q;
  assign data_o      = data_q;
  assign grant_idx_o = last_q;
  assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_bsg_mesh_out_port_sched.sv
// tb/tb_bsg_mesh_out_port_sched.sv - scoreboard bench with behavioural round-robin reference model
module tb_bsg_mesh_out_port_sched;

  localparam int D    = 5;
  localparam int W    = 10;
  localparam int MAXW = 4;
  localparam logic [D-1:0] MASK = 5'b11101;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [D-1:0]   v_i = '0;
  logic [D*W-1:0] data_i = '0;
  logic           ready_and_i = 1'b0;
  logic [D-1:0]   yumi_o;
  logic           v_o;
  logic [W-1:0]   data_o;
  logic [2:0]     grant_idx_o;
  logic [D-1:0]   starve_o;
  logic           illegal_o;

  always #5 clk = ~clk;

  bsg_mesh_out_port_sched #(
    .dirs_p(D), .width_p(W), .allowed_mask_p(MASK), .max_wait_p(MAXW)
  ) dut (
    .clk(clk), .reset(reset), .v_i(v_i), .data_i(data_i), .yumi_o(yumi_o),
    .v_o(v_o), .data_o(data_o), .ready_and_i(ready_and_i),
    .grant_idx_o(grant_idx_o), .starve_o(starve_o), .illegal_o(illegal_o)
  );

  int n_total = 0;
  int n_pass  = 0;
  bit done    = 0;

  // Reference model state: who was served last, whether the link holds a flit, how long each input waited.
  int           m_last;
  int           m_win;
  bit           m_v;
  int           m_wait [D];
  bit           m_ill;
  logic [D-1:0] exp_yumi;
  logic [W-1:0] sb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
  endtask

  task automatic model_reset();
    m_last = D - 1;
    m_win  = 0;
    m_v    = 0;
    m_ill  = 0;
    for (int k = 0; k < D; k++) m_wait[k] = 0;
    exp_yumi = '0;
    sb.delete();
  endtask

  task automatic model_comb();
    logic [D-1:0] elig;
    bit load;
    elig     = v_i & MASK;
    exp_yumi = '0;
    load     = (elig != 0) && (!m_v || ready_and_i) && !reset;
    if (load) begin
      for (int off = 1; off <= D; off++) begin
        int k;
        k = (m_last + off) % D;
        if (elig[k]) begin
          m_win = k;
          break;
        end
      end
      exp_yumi[m_win] = 1'b1;
      sb.push_back(data_i[m_win*W +: W]);
    end
  endtask

  task automatic model_seq();
    logic [D-1:0] elig;
    elig = v_i & MASK;
    for (int k = 0; k < D; k++) begin
      if (!elig[k] || exp_yumi[k]) m_wait[k] = 0;
      else if (m_wait[k] < MAXW) m_wait[k] = m_wait[k] + 1;
    end
    if (exp_yumi != 0) begin
      m_v    = 1;
      m_last = m_win;
    end else if (m_v && ready_and_i) begin
      m_v = 0;
    end
    if ((v_i & ~MASK) != 0) m_ill = 1;
  endtask

  task automatic step(input logic [D-1:0] v, input logic [D*W-1:0] d, input logic rdy);
    v_i = v;
    data_i = d;
    ready_and_i = rdy;
    model_comb();
    @(posedge clk);
    model_seq();
    #1;
  endtask

  function automatic logic [D*W-1:0] rnd_data();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[D*W-1:0];
  endfunction

  // Reset lands mid-cycle while inputs stay applied; outputs must collapse before the next edge.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    chk("rst_v_o", v_o, 0);
    chk("rst_data_o", data_o, 0);
    chk("rst_grant_idx", grant_idx_o, D - 1);
    chk("rst_yumi", yumi_o, 0);
    chk("rst_illegal", illegal_o, 0);
    chk("rst_starve", starve_o, 0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [D-1:0] exp_st;
    while (!done) begin
      @(negedge clk);
      chk("yumi_o", yumi_o, exp_yumi);
      chk("v_o", v_o, m_v);
      chk("grant_idx_o", grant_idx_o, m_last);
      for (int k = 0; k < D; k++) exp_st[k] = (m_wait[k] == MAXW);
      chk("starve_o", starve_o, exp_st);
      chk("illegal_o", illegal_o, m_ill);
      if (v_o) begin
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          chk("data_o", data_o, sb[0]);
          if (ready_and_i) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    logic [D*W-1:0] d;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    d = '0; d[W-1:0] = 10'h2A5;
    step(5'b00001, d, 1'b1);
    step(5'b00000, d, 1'b1);
    chk("single_data", data_o, 10'h2A5);
    step(5'b00000, d, 1'b1);

    for (int i = 0; i < 10; i++) step(5'b11111, rnd_data(), 1'b1);
    step(5'b00000, '0, 1'b1);

    step(5'b00001, rnd_data(), 1'b1);
    for (int i = 0; i < 3; i++) step(5'b01100, rnd_data(), 1'b0);
    chk("bp_wait2", m_wait[2], 3);
    step(5'b01100, rnd_data(), 1'b1);
    step(5'b00000, '0, 1'b1);

    step(5'b00001, rnd_data(), 1'b1);
    for (int i = 0; i < 6; i++) step(5'b01000, rnd_data(), 1'b0);
    chk("starve3", starve_o[3], 1);
    step(5'b01000, rnd_data(), 1'b1);
    step(5'b00000, '0, 1'b1);
    chk("starve3_clear", starve_o[3], 0);

    step(5'b00001, rnd_data(), 1'b1);
    do_reset();
    for (int i = 0; i < 3; i++) step(5'b00010, rnd_data(), 1'b1);
    chk("illegal_sticky", illegal_o, 1);
    step(5'b00000, '0, 1'b1);
    do_reset();

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(59) == 0) do_reset();
      step(D'($urandom), rnd_data(), $urandom_range(3) != 0);
    end

    for (int i = 0; i < 3; i++) step(5'b00000, '0, 1'b1);
    chk("sb_drained", sb.size(), 0);

    done = 1;
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
